modmul_arbiter: RTL and testbench
=================================

// Module: modmul_arbiter
// PURPOSE
//  Round-robin scheduler that shares one ModMul (a*b mod p) instance among NREQ requesters.
//  Accepts one operand pair at a time, sequences the multiplier's sync reset/enable/done protocol,
//  and returns the result tagged with the requester id. Includes a watchdog for a hung multiplier.
//  Sits between the MSM bucket/point-add engines and the shared modular multiplier.
// PARAMETERS
//  WIDTH   128   operand/result width; must match the attached ModMul width
//  NREQ    4     number of requesters (2..16)
//  TIMEOUT 1023  max BUSY cycles before an error response is returned
//  IDW     $clog2(NREQ)  id width (derived localparam, not overridable)
// PORTS
//  clk        in   1           clock
//  reset      in   1           asynchronous, active-low reset
//  req_valid  in   NREQ        per-requester operand valid
//  req_ready  out  NREQ        per-requester accept (one-hot or zero)
//  req_a      in   NREQ*WIDTH  packed operand a; slice i = requester i
//  req_b      in   NREQ*WIDTH  packed operand b
//  rsp_valid  out  1           result valid
//  rsp_ready  in   1           result consumer ready
//  rsp_r      out  WIDTH       a*b mod p (0 when rsp_err)
//  rsp_id     out  IDW         requester index of this result
//  rsp_err    out  1           watchdog expired; result invalid
//  mm_reset   out  1           sync active-high reset to ModMul
//  mm_enable  out  1           ModMul enable (level)
//  mm_a/mm_b  out  WIDTH       operands to ModMul, held stable LAUNCH..RESP
//  mm_r       in   WIDTH       ModMul result
//  mm_done    in   1           ModMul completion
//  busy       out  1           high in any state except IDLE
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, last_grant=NREQ-1, all outputs 0 except mm_reset=1.
//  FSM IDLE -> LAUNCH -> BUSY -> RESP -> IDLE.
//  IDLE:   mm_reset=1, mm_enable=0. If any req_valid: grant g = first valid index after last_grant
//          (wrap mod NREQ); req_ready[g]=1 combinationally this cycle; capture a,b,g; last_grant<=g;
//          -> LAUNCH. req_ready is 0 in every other state.
//  LAUNCH: exactly 1 cycle; mm_reset=1, mm_enable=0, operands already on mm_a/mm_b; clear wdog.
//  BUSY:   mm_reset=0, mm_enable=1; wdog++ each cycle. mm_done=1 -> capture mm_r, err=0 -> RESP.
//          wdog==TIMEOUT with mm_done=0 -> r=0, err=1 -> RESP. mm_done wins if both in same cycle.
//  RESP:   rsp_valid=1 with r/id/err stable, mm_enable=0, mm_reset=0; hold until rsp_ready=1 ->
//          IDLE. rsp_valid stays high while rsp_ready=0 (no drop, no change).
//  mm_done is ignored outside BUSY (stale done from a previous op must not complete a new one).
//  Latency: accept at cycle T; rsp_valid earliest T+3 (mm_done in first BUSY cycle).
//  Throughput: 1 op in flight; next accept no earlier than the cycle after RESP handshake.
//  Requester dropping req_valid before grant: legal, simply not granted. Payload sampled only
//  on the grant cycle.
//  Reset asserted mid-operation: in-flight op discarded, no response; mm_reset=1 immediately.
// STRUCTURE
//  Shared package modmul_pkg: FSM state encoding (IDLE/LAUNCH/BUSY/RESP), default WIDTH,
//  watchdog width function.
//  One sub-module: rr_arbiter (NREQ req vector + last_grant -> one-hot grant + index), pure
//  combinational.
//  ModMul is instantiated by the parent, not inside this block.
// TESTING
//  1. Single req: req_valid=0001, a=5, b=9, model ModMul p=37 done after 6 BUSY cycles ->
//     rsp_r=8, rsp_id=0, rsp_err=0.
//  2. All 4 valid continuously -> grants in order 0,1,2,3,0; last_grant wraps; no starvation.
//  3. rsp_ready held 0 for 10 cycles -> rsp_valid/r/id stable; req_ready=0 throughout;
//     accept resumes one cycle after the handshake.
//  4. Model never raises mm_done, TIMEOUT=15 -> rsp_err=1, rsp_r=0 exactly 16 BUSY cycles after
//     entry.
//  5. mm_done pulsed in IDLE/LAUNCH -> ignored; the op completes only on done seen in BUSY.
//  6. reset=0 during BUSY -> immediate IDLE, mm_reset=1, rsp_valid=0; the next request is
//     served normally.

Source files
------------

// File: rtl/modmul_pkg.sv
// Shared definitions for the ModMul round-robin scheduler: FSM state encoding,
// default datapath width and the watchdog counter sizing helper.
package modmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 128;

    // Bits needed for a counter that must be able to hold the value 'timeout'.
    function automatic int wdog_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/modmul_arbiter_if.sv
// Bundle of the requester, response and ModMul-side signals of the scheduler.
// 'master' is the scheduler's view; 'slave' is the view of whatever surrounds it
// (requesters, result consumer and the attached ModMul).
interface modmul_arbiter_if
    import modmul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    // requester side
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;

    // response side
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_r;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_err;

    // ModMul side
    logic                  mm_reset;
    logic                  mm_enable;
    logic [WIDTH-1:0]      mm_a;
    logic [WIDTH-1:0]      mm_b;
    logic [WIDTH-1:0]      mm_r;
    logic                  mm_done;

    modport master (
        input  req_valid, req_a, req_b, rsp_ready, mm_r, mm_done,
        output req_ready, rsp_valid, rsp_r, rsp_id, rsp_err,
               mm_reset, mm_enable, mm_a, mm_b
    );

    modport slave (
        output req_valid, req_a, req_b, rsp_ready, mm_r, mm_done,
        input  req_ready, rsp_valid, rsp_r, rsp_id, rsp_err,
               mm_reset, mm_enable, mm_a, mm_b
    );

endinterface

// File: rtl/modmul_arbiter_rr.sv
// Round-robin pick: the first asserted request strictly after last_grant,
// wrapping around to index 0. Purely combinational.
module rr_arbiter #(
    parameter int  NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_valid
);

    // Search indices above last_grant first, then wrap to the low indices.
    always_comb begin
        // NOTE: every output gets a default before the loops, so no path leaves one unassigned and no latch is inferred.
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_valid && req[i] && (i > int'(last_grant))) begin
                grant[i]    = 1'b1;
                grant_idx   = IDW'(i);
                grant_valid = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_valid && req[i] && (i <= int'(last_grant))) begin
                grant[i]    = 1'b1;
                grant_idx   = IDW'(i);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/modmul_arbiter.sv
// Shares one ModMul (a*b mod p) among NREQ requesters. One operation in flight:
// grant -> one-cycle ModMul reset (LAUNCH) -> enabled run until done or watchdog
// expiry (BUSY) -> hold the tagged result until consumed (RESP).
module modmul_arbiter
    import modmul_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    modmul_arbiter_if.master bus,
    output logic             busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int WDW = wdog_width(TIMEOUT);

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   last_grant_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic             err_q;
    logic [WDW-1:0]   wdog_q;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             grant_valid;
    logic             accept;
    logic             wdog_expired;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req         (bus.req_valid),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // A grant is only offered from IDLE and never while reset is held.
    assign accept        = (state_q == ST_IDLE) && grant_valid && reset;
    assign bus.req_ready = accept ? grant : '0;
    assign wdog_expired  = (wdog_q == WDW'(TIMEOUT));

    assign busy          = (state_q != ST_IDLE);
    assign bus.mm_a      = a_q;
    assign bus.mm_b      = b_q;
    assign bus.rsp_r     = r_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_err   = err_q;

    // State register; reset drops any in-flight operation back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values regardless of block order.
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and ModMul/response control decoded from the current state.
    always_comb begin
        state_d       = state_q;
        bus.mm_reset  = 1'b0;
        bus.mm_enable = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.mm_reset = 1'b1;
                if (grant_valid) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                bus.mm_reset = 1'b1;
                state_d      = ST_BUSY;
            end
            ST_BUSY: begin
                bus.mm_enable = 1'b1;
                // mm_done is only looked at here, so a stale done can't finish a new op.
                if (bus.mm_done || wdog_expired) state_d = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture on grant, watchdog, and result/error capture at the end of BUSY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: operand/result registers are reset too, because they drive mm_a/mm_b/rsp_r directly and must read 0 out of reset.
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            r_q          <= '0;
            err_q        <= 1'b0;
            wdog_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        a_q          <= bus.req_a[grant_idx*WIDTH +: WIDTH];
                        b_q          <= bus.req_b[grant_idx*WIDTH +: WIDTH];
                        id_q         <= grant_idx;
                        last_grant_q <= grant_idx;
                    end
                end
                ST_LAUNCH: wdog_q <= '0;
                ST_BUSY: begin
                    wdog_q <= wdog_q + WDW'(1);
                    if (bus.mm_done) begin
                        r_q   <= bus.mm_r;
                        err_q <= 1'b0;
                    end else if (wdog_expired) begin
                        r_q   <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed bench for modmul_arbiter: per-requester operand queues drive the
// request side, a behavioural ModMul (p = 37) answers on the multiplier side,
// and a monitor checks each response against a queue of hand-computed results.
module tb_modmul_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TO = 15;
    localparam int P  = 37;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    modmul_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

    modmul_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master),
        .busy  (busy)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [W-1:0] r;
        logic [1:0]   id;
        logic         err;
        int           busy_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic expect_rsp(input logic [W-1:0] r, input int id, input logic err, input int bc);
        exp_t e;
        e.r        = r;
        e.id       = 2'(id);
        e.err      = err;
        e.busy_cyc = bc;
        sb.push_back(e);
    endtask

    // ---------------- requester queues ----------------
    logic [W-1:0] pa [N][8];
    logic [W-1:0] pb [N][8];
    int           p_head [N];
    int           p_tail [N];
    logic [N-1:0] acc = '0;

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        pa[i][p_tail[i] % 8] = a;
        pb[i][p_tail[i] % 8] = b;
        p_tail[i]++;
    endtask

    function automatic bit pending();
        for (int i = 0; i < N; i++)
            if (p_head[i] != p_tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Accepts are seen at the negedge before the accepting posedge.
    always @(negedge clk) acc = reset ? (bus.req_valid & bus.req_ready) : '0;

    // Requester driver: retire accepted entries, present the next payload.
    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) p_head[i]++;
                if (p_head[i] != p_tail[i]) begin
                    bus.req_valid[i]     = 1'b1;
                    bus.req_a[i*W +: W]  = pa[i][p_head[i] % 8];
                    bus.req_b[i*W +: W]  = pb[i][p_head[i] % 8];
                end else begin
                    bus.req_valid[i]     = 1'b0;
                    bus.req_a[i*W +: W]  = '0;
                    bus.req_b[i*W +: W]  = '0;
                end
            end
        end
    end

    // ---------------- ModMul model ----------------
    int           mm_cnt     = 0;
    int           mm_lat     = 6;
    bit           mm_hang    = 1'b0;
    logic         model_done = 1'b0;
    logic [W-1:0] model_r    = '0;
    logic         force_done = 1'b0;

    always @(negedge clk) begin
        if (!reset || bus.mm_reset) begin
            mm_cnt     = 0;
            model_done = 1'b0;
        end else if (bus.mm_enable) begin
            mm_cnt++;
            if (!mm_hang && mm_cnt >= mm_lat) begin
                model_done = 1'b1;
                model_r    = W'((64'(bus.mm_a) * 64'(bus.mm_b)) % 64'(P));
            end
        end else begin
            model_done = 1'b0;
        end
    end

    assign bus.mm_done = model_done | force_done;
    assign bus.mm_r    = model_done ? model_r : 32'hDEAD_BEEF;

    // ---------------- monitor ----------------
    int launch_cnt = 0;
    int busy_cnt   = 0;

    always @(negedge clk) begin
        if (!reset || !busy) begin
            launch_cnt = 0;
            busy_cnt   = 0;
        end else begin
            if (bus.mm_reset)  launch_cnt++;
            if (bus.mm_enable) busy_cnt++;
        end
        if (reset) begin
            check("req_ready_onehot0", 64'($onehot0(bus.req_ready)), 1);
            if (busy) check("req_ready_while_busy", bus.req_ready, 0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("rsp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("rsp_r",         bus.rsp_r,   mon_e.r);
                    check("rsp_id",        bus.rsp_id,  mon_e.id);
                    check("rsp_err",       bus.rsp_err, mon_e.err);
                    check("launch_cycles", launch_cnt,  1);
                    check("busy_cycles",   busy_cnt,    mon_e.busy_cyc);
                end
            end
        end
    end

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while ((sb.size() != 0 || pending() || busy) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_drained"}, {sb.size() != 0, pending(), busy}, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        for (int i = 0; i < N; i++) begin
            p_head[i] = 0;
            p_tail[i] = 0;
        end
        bus.rsp_ready = 1'b1;

        // Reset state, with a request already pending during reset.
        issue(0, 5, 9);
        expect_rsp(8, 0, 1'b0, 6);
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_busy",      busy,          0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_mm_reset",  bus.mm_reset,  1);
        check("rst_mm_enable", bus.mm_enable, 0);
        check("rst_rsp_r",     bus.rsp_r,     0);
        check("rst_rsp_id",    bus.rsp_id,    0);
        check("rst_rsp_err",   bus.rsp_err,   0);
        check("rst_mm_a",      bus.mm_a,      0);
        check("rst_mm_b",      bus.mm_b,      0);

        // 1: single request 5*9 mod 37 = 8, done after 6 BUSY cycles.
        @(posedge clk); #1;
        reset = 1'b1;
        drain("t1", 100);

        // 2: all requesters valid; order 0,1,2,3,0,1 from a fresh last_grant.
        reset = 1'b0;
        @(posedge clk); #1;
        reset  = 1'b1;
        mm_lat = 1;
        issue(0, 6, 7);    expect_rsp(5,  0, 1'b0, 1);
        issue(1, 10, 11);  expect_rsp(36, 1, 1'b0, 1);
        issue(2, 12, 13);  expect_rsp(8,  2, 1'b0, 1);
        issue(3, 36, 36);  expect_rsp(1,  3, 1'b0, 1);
        issue(0, 100, 3);  expect_rsp(4,  0, 1'b0, 1);
        issue(1, 2, 20);   expect_rsp(3,  1, 1'b0, 1);
        @(negedge clk);
        check("t2_first_grant", bus.req_ready, 4'b0001);
        drain("t2", 200);

        // 3: consumer stalls 10 cycles; response held, no accepts, resume after handshake.
        mm_lat        = 3;
        bus.rsp_ready = 1'b0;
        issue(2, 3, 4);   expect_rsp(12, 2, 1'b0, 3);
        issue(3, 20, 2);  expect_rsp(3,  3, 1'b0, 3);
        k = 0;
        @(negedge clk);
        while (!bus.rsp_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t3_rsp_seen", bus.rsp_valid, 1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            check("t3_hold_valid",     bus.rsp_valid, 1);
            check("t3_hold_r",         bus.rsp_r,     12);
            check("t3_hold_id",        bus.rsp_id,    2);
            check("t3_hold_err",       bus.rsp_err,   0);
            check("t3_hold_req_ready", bus.req_ready, 0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t3_resume_req_ready", bus.req_ready, 4'b1000);
        check("t3_resume_rsp_valid", bus.rsp_valid, 0);
        drain("t3", 100);

        // 4: hung multiplier -> error response after 16 BUSY cycles.
        mm_hang = 1'b1;
        issue(0, 7, 7);
        expect_rsp(0, 0, 1'b1, 16);
        drain("t4", 100);
        mm_hang = 1'b0;

        // 5: done pulsed through IDLE and LAUNCH is ignored; 9*9 mod 37 = 7.
        mm_lat     = 4;
        force_done = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        issue(1, 9, 9);
        expect_rsp(7, 1, 1'b0, 4);
        k = 0;
        @(negedge clk);
        while (!(busy && bus.mm_reset) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5_launch_seen", busy && bus.mm_reset, 1);
        @(posedge clk); #1;
        force_done = 1'b0;
        drain("t5", 100);

        // 6: reset during BUSY discards the op; next request served normally.
        mm_lat = 8;
        issue(2, 11, 11);
        k = 0;
        @(negedge clk);
        while (!bus.mm_enable && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t6_busy_seen", bus.mm_enable, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("t6_rst_busy",      busy,          0);
        check("t6_rst_mm_reset",  bus.mm_reset,  1);
        check("t6_rst_mm_enable", bus.mm_enable, 0);
        check("t6_rst_rsp_valid", bus.rsp_valid, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset  = 1'b1;
        mm_lat = 2;
        issue(3, 30, 30);
        expect_rsp(12, 3, 1'b0, 2);
        drain("t6", 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1, "tb_modmul_arbiter: time limit expired");
    end

endmodule
